// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - half-duplex bus responder with write capture, turnaround read and drop counter
module bus_responder #(
    parameter int                 WIDTH = 10,
    parameter logic [WIDTH-1:0]   INIT  = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req,
    input  logic             i_wr,
    inout  tri   [WIDTH-1:0] io_bus,
    output logic             o_ack,
    output logic             o_busy,
    output logic             o_oe,
    output logic [WIDTH-1:0] o_data,
    output logic [7:0]       o_drop_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WACK  = 3'd1,
        TURN  = 3'd2,
        DRIVE = 3'd3,
        RACK  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [7:0]         drop_q, drop_d;
    logic               ack_q, busy_q, oe_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (i_wr) begin
                        data_d  = io_bus;
                        state_d = WACK;
                    end else begin
                        state_d = TURN;
                    end
                end
            end
            WACK:    state_d = IDLE;
            TURN:    state_d = DRIVE;
            DRIVE:   state_d = RACK;
            RACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Requests arriving mid-transaction are only counted, never acted on.
        if (i_req && (state_q != IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Output flags are registered from the next state so they line up with state_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= INIT;
            drop_q  <= 8'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            ack_q   <= (state_d == WACK) || (state_d == RACK);
            busy_q  <= (state_d != IDLE);
            oe_q    <= (state_d == DRIVE);
        end
    end

    assign io_bus     = oe_q ? data_q : {WIDTH{1'bz}};
    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_oe       = oe_q;
    assign o_data     = data_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed self-checking bench for bus_responder
module tb_bus_responder;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_req;
    logic       i_wr;
    tri   [9:0] io_bus;
    logic       o_ack;
    logic       o_busy;
    logic       o_oe;
    logic [9:0] o_data;
    logic [7:0] o_drop_cnt;

    logic [9:0] tb_drv;
    logic       tb_en;

    int checks;
    int errors;

    assign io_bus = tb_en ? tb_drv : 10'bz;

    bus_responder #(.WIDTH(10), .INIT(10'h000)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_wr       (i_wr),
        .io_bus     (io_bus),
        .o_ack      (o_ack),
        .o_busy     (o_busy),
        .o_oe       (o_oe),
        .o_data     (o_data),
        .o_drop_cnt (o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // The bench briefly drives a probe pattern; it reads back intact only if the DUT has released the bus.
    task automatic bus_released(input string tag);
        logic [9:0] save_drv;
        logic       save_en;
        save_drv = tb_drv;
        save_en  = tb_en;
        tb_drv   = 10'h155;
        tb_en    = 1'b1;
        #1;
        chk(tag, {22'd0, io_bus}, 32'h155);
        tb_drv   = save_drv;
        tb_en    = save_en;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        i_wr    = 1'b0;
        tb_drv  = 10'h000;
        tb_en   = 1'b0;
        repeat (2) step();

        chk("rst_data", {22'd0, o_data}, 32'h000);
        chk("rst_oe", {31'd0, o_oe}, 32'd0);
        chk("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        bus_released("rst_bus_z");
        i_rst_n = 1'b1;
        step();

        // Write 2A5 then read it back.
        i_req = 1'b1; i_wr = 1'b1; tb_drv = 10'h2A5; tb_en = 1'b1;
        step();
        chk("wr_ack", {31'd0, o_ack}, 32'd1);
        chk("wr_data", {22'd0, o_data}, 32'h2A5);
        chk("wr_busy", {31'd0, o_busy}, 32'd1);
        i_req = 1'b0; tb_en = 1'b0;
        step();
        chk("wr_idle_ack", {31'd0, o_ack}, 32'd0);
        chk("wr_idle_busy", {31'd0, o_busy}, 32'd0);

        i_req = 1'b1; i_wr = 1'b0;
        step();
        chk("rd_turn_oe", {31'd0, o_oe}, 32'd0);
        chk("rd_turn_ack", {31'd0, o_ack}, 32'd0);
        bus_released("rd_turn_bus_z");
        i_req = 1'b0;
        step();
        chk("rd_drive_oe", {31'd0, o_oe}, 32'd1);
        chk("rd_drive_bus", {22'd0, io_bus}, 32'h2A5);
        chk("rd_drive_ack", {31'd0, o_ack}, 32'd0);
        step();
        chk("rd_rack_ack", {31'd0, o_ack}, 32'd1);
        chk("rd_rack_oe", {31'd0, o_oe}, 32'd0);
        bus_released("rd_rack_bus_z");
        step();
        chk("rd_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("rd_nondestructive", {22'd0, o_data}, 32'h2A5);

        // Read request held high: drops in TURN, DRIVE, RACK, then second read accepted.
        i_req = 1'b1; i_wr = 1'b0;
        step();
        bus_released("hold_turn1_bus_z");
        step();
        chk("hold_drop1", {24'd0, o_drop_cnt}, 32'd1);
        chk("hold_drive_oe", {31'd0, o_oe}, 32'd1);
        step();
        chk("hold_drop2", {24'd0, o_drop_cnt}, 32'd2);
        step();
        chk("hold_drop3", {24'd0, o_drop_cnt}, 32'd3);
        chk("hold_idle_busy", {31'd0, o_busy}, 32'd0);
        step();
        chk("hold_second_accept", {31'd0, o_busy}, 32'd1);
        chk("hold_second_turn_oe", {31'd0, o_oe}, 32'd0);
        chk("hold_drop_after4", {24'd0, o_drop_cnt}, 32'd3);
        bus_released("hold_turn2_bus_z");
        i_req = 1'b0;
        repeat (3) step();
        chk("hold_done_busy", {31'd0, o_busy}, 32'd0);
        chk("hold_drop_final", {24'd0, o_drop_cnt}, 32'd3);

        // Reset while driving the bus.
        i_req = 1'b1; i_wr = 1'b0;
        step();
        i_req = 1'b0;
        step();
        chk("rstd_in_drive", {31'd0, o_oe}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rstd_oe", {31'd0, o_oe}, 32'd0);
        chk("rstd_ack", {31'd0, o_ack}, 32'd0);
        chk("rstd_busy", {31'd0, o_busy}, 32'd0);
        chk("rstd_drop", {24'd0, o_drop_cnt}, 32'd0);
        chk("rstd_data", {22'd0, o_data}, 32'h000);
        bus_released("rstd_bus_z");
        step();
        chk("rstd_no_ack", {31'd0, o_ack}, 32'd0);
        i_rst_n = 1'b1;
        i_req = 1'b1; i_wr = 1'b1; tb_drv = 10'h1C3; tb_en = 1'b1;
        step();
        chk("post_rst_accept_ack", {31'd0, o_ack}, 32'd1);
        chk("post_rst_accept_data", {22'd0, o_data}, 32'h1C3);
        i_req = 1'b0; tb_en = 1'b0;
        step();

        // 400 cycles of held reads produce 300 drops; the counter must pin at 255.
        i_req = 1'b1; i_wr = 1'b0;
        repeat (400) step();
        chk("sat_drop", {24'd0, o_drop_cnt}, 32'd255);
        i_req = 1'b0;
        begin
            int n;
            n = 0;
            while (o_busy && n < 8) begin
                step();
                n++;
            end
            chk("sat_idle_timeout", {31'd0, o_busy}, 32'd0);
        end
        chk("sat_drop_hold", {24'd0, o_drop_cnt}, 32'd255);
        chk("sat_data_kept", {22'd0, o_data}, 32'h1C3);

        // Alternating write 3FF / read with i_req held high throughout.
        i_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("alt%0d_idle", k), {31'd0, o_busy}, 32'd0);
            if ((k % 2) == 0) begin
                i_wr = 1'b1; tb_drv = 10'h3FF; tb_en = 1'b1;
                step();
                chk($sformatf("alt%0d_wr_ack", k), {31'd0, o_ack}, 32'd1);
                chk($sformatf("alt%0d_wr_data", k), {22'd0, o_data}, 32'h3FF);
                tb_en = 1'b0; i_wr = 1'b0;
                step();
            end else begin
                i_wr = 1'b0;
                step();
                chk($sformatf("alt%0d_rd_busy", k), {31'd0, o_busy}, 32'd1);
                step();
                chk($sformatf("alt%0d_rd_bus", k), {22'd0, io_bus}, 32'h3FF);
                step();
                chk($sformatf("alt%0d_rd_ack", k), {31'd0, o_ack}, 32'd1);
                step();
            end
        end
        i_req = 1'b0;
        step();
        chk("alt_end_busy", {31'd0, o_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
